// File: rtl/exu_ctrl_queue.sv
// exu_ctrl_queue
//   Execute-to-writeback control stage. Holds up to DEPTH EXU results with
//   their control bits in a small FIFO. Both sides use valid/ready
//   handshakes. Conditional branches are resolved at the queue head.
//   o_jump is raised toward IFU/WBU on a trap, an unconditional jump or a
//   taken branch.
//
// Parameters
//   XLEN     data / PC width
//   ALU_T_W  alu_t width. Branch codes have the MSB set and the middle bits
//            clear, so ALU_T_W must be at least 4.
//   DEPTH    FIFO entries (1..8). DEPTH=1 accepts at most every other cycle.
//
// Ports
//   i_clock, i_reset (async, active low), i_flush (sync, clears all entries)
//   upstream  : i_valid / o_ready, i_alu_t, i_cmp, i_zero, i_result_t,
//               i_reg_wen, i_csr_wen, i_jump, i_trap, i_result, i_upc
//   downstream: o_valid / i_ready, o_upc, o_result, o_result_t, o_reg_wen,
//               o_csr_wen, o_branch, o_jump (all zero while o_valid=0)
//
// Optional feature (macro EXU_CTRL_PERF_EN)
//   Adds o_perf_br and o_perf_taken. These are 32-bit wrapping counters of
//   popped branch ops and popped taken branches. Only reset clears them;
//   flush does not.

module exu_ctrl_queue #(
  parameter int XLEN    = 32,
  parameter int ALU_T_W = 4,
  parameter int DEPTH   = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  // upstream
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [ALU_T_W-1:0] i_alu_t,
  input  logic               i_cmp,
  input  logic               i_zero,
  input  logic               i_result_t,
  input  logic               i_reg_wen,
  input  logic               i_csr_wen,
  input  logic               i_jump,
  input  logic               i_trap,
  input  logic [XLEN-1:0]    i_result,
  input  logic [XLEN-1:0]    i_upc,
  // downstream
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_upc,
  output logic [XLEN-1:0]    o_result,
  output logic               o_result_t,
  output logic               o_reg_wen,
  output logic               o_csr_wen,
  output logic               o_branch,
  output logic               o_jump
`ifdef EXU_CTRL_PERF_EN
  ,
  output logic [31:0]        o_perf_br,
  output logic [31:0]        o_perf_taken
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Branch encodings: MSB set, low three bits select the condition.
  localparam logic [ALU_T_W-1:0] BR_MSB  = {1'b1, {(ALU_T_W-1){1'b0}}};
  localparam logic [ALU_T_W-1:0] BR_BEQ  = BR_MSB | ALU_T_W'(3'b000);
  localparam logic [ALU_T_W-1:0] BR_BNE  = BR_MSB | ALU_T_W'(3'b001);
  localparam logic [ALU_T_W-1:0] BR_BLT  = BR_MSB | ALU_T_W'(3'b100);
  localparam logic [ALU_T_W-1:0] BR_BGE  = BR_MSB | ALU_T_W'(3'b101);
  localparam logic [ALU_T_W-1:0] BR_BLTU = BR_MSB | ALU_T_W'(3'b110);
  localparam logic [ALU_T_W-1:0] BR_BGEU = BR_MSB | ALU_T_W'(3'b111);

  typedef struct packed {
    logic [XLEN-1:0]    upc;
    logic [XLEN-1:0]    result;
    logic [ALU_T_W-1:0] alu_t;
    logic               cmp;
    logic               zero;
    logic               result_t;
    logic               reg_wen;
    logic               csr_wen;
    logic               jump;
    logic               trap;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           wr_entry;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic             br_taken;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Wraps modulo DEPTH. DEPTH need not be a power of two.
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = '0;
    else                        ptr_inc = p + 1'b1;
  endfunction

  // o_ready depends on registered count only. A full queue refuses a push
  // even when the head pops in the same cycle.
  assign o_ready = (count != CNT_W'(DEPTH));
  assign o_valid = (count != '0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      // A pop handshake can still be seen downstream this cycle. Its
      // pointer update and any push are dropped.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    wr_entry          = '0;
    wr_entry.upc      = i_upc;
    wr_entry.result   = i_result;
    wr_entry.alu_t    = i_alu_t;
    wr_entry.cmp      = i_cmp;
    wr_entry.zero     = i_zero;
    wr_entry.result_t = i_result_t;
    wr_entry.reg_wen  = i_reg_wen;
    wr_entry.csr_wen  = i_csr_wen;
    wr_entry.jump     = i_jump;
    wr_entry.trap     = i_trap;
  end

  // Payload storage is not reset. All outputs are gated by o_valid, so
  // stale or uninitialised entries are never visible.
  always_ff @(posedge i_clock) begin
    if (push && !i_flush) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    br_taken = 1'b0;
    case (head.alu_t)
      BR_BEQ:           br_taken = head.zero;
      BR_BNE:           br_taken = ~head.zero;
      BR_BLT, BR_BLTU:  br_taken = head.cmp;
      BR_BGE, BR_BGEU:  br_taken = ~head.cmp;
      default:          br_taken = 1'b0;
    endcase
  end

  assign o_upc      = o_valid ? head.upc    : '0;
  assign o_result   = o_valid ? head.result : '0;
  assign o_result_t = o_valid & head.result_t;
  assign o_reg_wen  = o_valid & head.reg_wen;
  assign o_csr_wen  = o_valid & head.csr_wen;
  assign o_branch   = o_valid & br_taken;
  assign o_jump     = o_valid & (head.trap | head.jump | br_taken);

`ifdef EXU_CTRL_PERF_EN
  logic head_is_br;

  always_comb begin
    head_is_br = 1'b0;
    case (head.alu_t)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: head_is_br = 1'b1;
      default:                                          head_is_br = 1'b0;
    endcase
  end

  // Pops are counted even during a flush, because downstream still sees
  // that handshake.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_perf_br    <= '0;
      o_perf_taken <= '0;
    end else begin
      if (pop && head_is_br) o_perf_br    <= o_perf_br + 32'd1;
      if (pop && o_branch)   o_perf_taken <= o_perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_ctrl_queue.sv
module tb_exu_ctrl_queue;

  logic        i_clock = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready;
  logic [3:0]  i_alu_t;
  logic        i_cmp, i_zero, i_result_t, i_reg_wen, i_csr_wen, i_jump, i_trap;
  logic [31:0] i_result, i_upc;

  logic        o_ready, o_valid, o_result_t, o_reg_wen, o_csr_wen, o_branch, o_jump;
  logic [31:0] o_upc, o_result;

  logic        d1_ready, d1_valid, d1_rt, d1_rw, d1_cw, d1_br, d1_jmp;
  logic [31:0] d1_upc, d1_res;
  logic        d4_ready, d4_valid, d4_rt, d4_rw, d4_cw, d4_br, d4_jmp;
  logic [31:0] d4_upc, d4_res;
`ifdef EXU_CTRL_PERF_EN
  logic [31:0] o_perf_br, o_perf_taken, d1_pb, d1_pt, d4_pb, d4_pt;
`endif

  always #5 i_clock = ~i_clock;

  exu_ctrl_queue #(.XLEN(32), .ALU_T_W(4), .DEPTH(2)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_alu_t(i_alu_t), .i_cmp(i_cmp),
    .i_zero(i_zero), .i_result_t(i_result_t), .i_reg_wen(i_reg_wen),
    .i_csr_wen(i_csr_wen), .i_jump(i_jump), .i_trap(i_trap),
    .i_result(i_result), .i_upc(i_upc), .o_valid(o_valid), .i_ready(i_ready),
    .o_upc(o_upc), .o_result(o_result), .o_result_t(o_result_t),
    .o_reg_wen(o_reg_wen), .o_csr_wen(o_csr_wen), .o_branch(o_branch),
    .o_jump(o_jump)
`ifdef EXU_CTRL_PERF_EN
    , .o_perf_br(o_perf_br), .o_perf_taken(o_perf_taken)
`endif
  );

  exu_ctrl_queue #(.XLEN(32), .ALU_T_W(4), .DEPTH(1)) dut_d1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(d1_ready), .i_alu_t(i_alu_t), .i_cmp(i_cmp),
    .i_zero(i_zero), .i_result_t(i_result_t), .i_reg_wen(i_reg_wen),
    .i_csr_wen(i_csr_wen), .i_jump(i_jump), .i_trap(i_trap),
    .i_result(i_result), .i_upc(i_upc), .o_valid(d1_valid), .i_ready(i_ready),
    .o_upc(d1_upc), .o_result(d1_res), .o_result_t(d1_rt),
    .o_reg_wen(d1_rw), .o_csr_wen(d1_cw), .o_branch(d1_br), .o_jump(d1_jmp)
`ifdef EXU_CTRL_PERF_EN
    , .o_perf_br(d1_pb), .o_perf_taken(d1_pt)
`endif
  );

  exu_ctrl_queue #(.XLEN(32), .ALU_T_W(4), .DEPTH(4)) dut_d4 (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(d4_ready), .i_alu_t(i_alu_t), .i_cmp(i_cmp),
    .i_zero(i_zero), .i_result_t(i_result_t), .i_reg_wen(i_reg_wen),
    .i_csr_wen(i_csr_wen), .i_jump(i_jump), .i_trap(i_trap),
    .i_result(i_result), .i_upc(i_upc), .o_valid(d4_valid), .i_ready(i_ready),
    .o_upc(d4_upc), .o_result(d4_res), .o_result_t(d4_rt),
    .o_reg_wen(d4_rw), .o_csr_wen(d4_cw), .o_branch(d4_br), .o_jump(d4_jmp)
`ifdef EXU_CTRL_PERF_EN
    , .o_perf_br(d4_pb), .o_perf_taken(d4_pt)
`endif
  );

  typedef struct {
    logic [31:0] upc, result;
    logic        result_t, reg_wen, csr_wen, branch, jump, is_br;
  } exp_t;

  typedef struct {
    logic [3:0] alu_t;
    logic       cmp, zero, jump, trap, exp_branch, exp_jump;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   exp_pbr = 0;
  int   exp_ptk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] at, input logic c, input logic z,
                       input logic j, input logic tr, input logic [31:0] upc,
                       input logic [31:0] res, input logic rt, input logic rw,
                       input logic cw, input logic eb, input logic ej);
    i_valid = 1'b1; i_alu_t = at; i_cmp = c; i_zero = z; i_jump = j; i_trap = tr;
    i_upc = upc; i_result = res; i_result_t = rt; i_reg_wen = rw; i_csr_wen = cw;
    cur_exp.upc = upc; cur_exp.result = res; cur_exp.result_t = rt;
    cur_exp.reg_wen = rw; cur_exp.csr_wen = cw; cur_exp.branch = eb; cur_exp.jump = ej;
    cur_exp.is_br = at[3] && !(at[2:0] == 3'b010 || at[2:0] == 3'b011);
  endtask

  // Runs at negedge+1: checks the outputs against the model, then advances
  // the model by one clock.
  task automatic tick();
    int   n;
    logic do_pop, do_push;
    n = sb.size();
    chk("o_valid", {63'd0, o_valid}, {63'd0, n != 0});
    chk("o_ready", {63'd0, o_ready}, {63'd0, n != 2});
    if (n != 0) begin
      chk("head_upc",    {32'd0, o_upc},    {32'd0, sb[0].upc});
      chk("head_result", {32'd0, o_result}, {32'd0, sb[0].result});
      chk("head_ctrl", {59'd0, o_result_t, o_reg_wen, o_csr_wen, o_branch, o_jump},
          {59'd0, sb[0].result_t, sb[0].reg_wen, sb[0].csr_wen, sb[0].branch, sb[0].jump});
    end else begin
      chk("idle_zero", {27'd0, o_upc | o_result, o_result_t, o_reg_wen, o_csr_wen, o_branch, o_jump}, 64'd0);
    end
    do_pop  = (n != 0) && i_ready;
    do_push = i_valid && (n != 2);
    if (do_pop) begin
      if (sb[0].is_br)  exp_pbr++;
      if (sb[0].branch) exp_ptk++;
    end
    if (i_flush) sb.delete();
    else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(cur_exp);
    end
    @(negedge i_clock); #1;
  endtask

  vec_t vecs[16];

  initial begin
    int acc1, acc4;
    vecs[0]  = '{4'b1000, 0, 1, 0, 0, 1, 1};  // BEQ taken
    vecs[1]  = '{4'b1000, 0, 0, 0, 0, 0, 0};  // BEQ not taken
    vecs[2]  = '{4'b1001, 0, 0, 0, 0, 1, 1};  // BNE taken
    vecs[3]  = '{4'b1001, 0, 1, 0, 0, 0, 0};
    vecs[4]  = '{4'b1100, 1, 0, 0, 0, 1, 1};  // BLT
    vecs[5]  = '{4'b1100, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{4'b1101, 1, 0, 0, 0, 0, 0};  // BGE
    vecs[7]  = '{4'b1101, 0, 0, 0, 0, 1, 1};
    vecs[8]  = '{4'b1110, 1, 0, 0, 0, 1, 1};  // BLTU
    vecs[9]  = '{4'b1111, 0, 1, 0, 0, 1, 1};  // BGEU
    vecs[10] = '{4'b1111, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{4'b1010, 1, 1, 0, 0, 0, 0};  // non-branch with MSB set
    vecs[12] = '{4'b1011, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{4'b0000, 0, 0, 1, 0, 0, 1};  // jump
    vecs[14] = '{4'b0000, 0, 1, 0, 1, 0, 1};  // trap
    vecs[15] = '{4'b0011, 1, 1, 0, 0, 0, 0};

    i_reset = 0; i_flush = 0; i_ready = 0;
    drive(4'b0000, 0, 0, 0, 0, 32'h1234, 32'h5678, 1, 1, 1, 0, 0);
    repeat (3) @(negedge i_clock); #1;

    // 1: reset with i_valid high
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_jump",  {63'd0, o_jump},  64'd0);
    chk("rst_payload", {32'd0, o_upc | o_result}, 64'd0);
    i_reset = 1;
    drive(4'b0000, 0, 0, 0, 0, 32'h8000_0000, 32'hAAAA_0001, 1, 1, 0, 0, 0);
    tick();
    i_valid = 0;
    chk("t1_latency", {63'd0, o_valid}, 64'd1);
    tick();
    i_ready = 1; tick(); tick();

    // 2: fill, refuse third push, drain in order
    i_ready = 0;
    drive(4'b0000, 0, 0, 0, 0, 32'h8000_0004, 32'h4, 0, 1, 0, 0, 0); tick();
    drive(4'b0000, 0, 0, 0, 0, 32'h8000_0008, 32'h8, 1, 0, 1, 0, 0); tick();
    chk("t2_full", {63'd0, o_ready}, 64'd0);
    drive(4'b0000, 0, 0, 0, 0, 32'h8000_000C, 32'hC, 0, 0, 0, 0, 0); tick();
    i_valid = 0; i_ready = 1;
    chk("t2_head0", {32'd0, o_upc}, 64'h8000_0004); tick();
    chk("t2_head1", {32'd0, o_upc}, 64'h8000_0008); tick();
    chk("t2_empty", {63'd0, o_valid}, 64'd0); tick();

    // 3: branch decode table, streamed with downstream always ready
    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].alu_t, vecs[k].cmp, vecs[k].zero, vecs[k].jump, vecs[k].trap,
            32'h9000_0000 + 32'(k * 4), 32'h100 + 32'(k), k[0], k[1], k[2],
            vecs[k].exp_branch, vecs[k].exp_jump);
      tick();
    end
    i_valid = 0; repeat (3) tick();

    // 4: flush a full queue with i_valid high, then flush during a pop
    i_ready = 0;
    drive(4'b1000, 0, 1, 0, 0, 32'hA000_0000, 32'h1, 0, 1, 0, 1, 1); tick();
    drive(4'b0000, 0, 0, 0, 0, 32'hA000_0004, 32'h2, 0, 1, 0, 0, 0); tick();
    i_flush = 1; tick();
    i_flush = 0; i_valid = 0;
    chk("t4_flushed", {63'd0, o_valid}, 64'd0);
    tick();
    drive(4'b1001, 0, 0, 0, 0, 32'hA000_0008, 32'h3, 1, 0, 0, 1, 1); tick();
    drive(4'b0000, 0, 0, 0, 0, 32'hA000_000C, 32'h4, 0, 0, 0, 0, 0);
    i_ready = 1; i_flush = 1; tick();
    i_flush = 0; i_valid = 0;
    chk("t4_flush_pop", {63'd0, o_valid}, 64'd0);
    tick();

    // reset mid-operation drops entries at once; release together with flush
    i_ready = 0;
    drive(4'b0000, 0, 0, 1, 0, 32'hB000_0000, 32'h5, 1, 1, 1, 0, 1); tick();
    drive(4'b0000, 0, 0, 0, 0, 32'hB000_0004, 32'h6, 1, 1, 1, 0, 0); tick();
    #1 i_reset = 0;
    #1;
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_ready", {63'd0, o_ready}, 64'd1);
    chk("midrst_out", {27'd0, o_upc | o_result, o_result_t, o_reg_wen, o_csr_wen, o_branch, o_jump}, 64'd0);
    sb.delete();
    @(negedge i_clock); #1;
    i_reset = 1; i_flush = 1;
    drive(4'b0000, 0, 0, 0, 0, 32'hB000_0008, 32'h7, 0, 0, 0, 0, 0); tick();
    i_flush = 0;

    // 5: throughput with continuous valid/ready (all three queues are empty)
    i_ready = 1; acc1 = 0; acc4 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(4'b0000, 0, 0, 0, 0, 32'hC000_0000 + 32'(k * 4), 32'(k), 0, 1, 0, 0, 0);
      acc1 += int'(d1_ready);
      acc4 += int'(d4_ready);
      tick();
    end
    chk("t5_depth1_accepts", 64'(acc1), 64'd4);
    chk("t5_depth4_accepts", 64'(acc4), 64'd8);
    i_valid = 0; repeat (3) tick();

`ifdef EXU_CTRL_PERF_EN
    // 6: BNE(taken), BEQ(not taken), ADD pop -> +2 branches, +1 taken
    begin
      int b0, t0;
      b0 = exp_pbr; t0 = exp_ptk;
      chk("perf_br_base", 64'(o_perf_br), 64'(b0));
      drive(4'b1001, 0, 0, 0, 0, 32'hD000_0000, 32'h0, 0, 0, 0, 1, 1); tick();
      drive(4'b1000, 0, 0, 0, 0, 32'hD000_0004, 32'h0, 0, 0, 0, 0, 0); tick();
      drive(4'b0000, 0, 0, 0, 0, 32'hD000_0008, 32'h0, 0, 1, 0, 0, 0); tick();
      i_valid = 0; repeat (3) tick();
      chk("perf_br",    64'(o_perf_br),    64'(b0 + 2));
      chk("perf_taken", 64'(o_perf_taken), 64'(t0 + 1));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
